// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data-memory responder with programmable wait states
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, err_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, access;
  logic            acc_we, acc_err;
  logic [3:0]      acc_be;
  logic [31:0]     acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr_i[1:0];

  assign req_ready_o = (state_q == S_IDLE) && reset_ni;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access uses the live request; otherwise the latched copy.
  always_comb begin
    acc_we    = we_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    acc_idx   = idx_q;
    acc_err   = err_q;
    if (state_q == S_IDLE) begin
      acc_we    = req_we_i;
      acc_be    = req_be_i;
      acc_wdata = req_wdata_i;
      acc_idx   = req_addr_i[AW+1:2];
      acc_err   = (req_addr_i[31:AW+2] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= acc_we;
        be_q    <= acc_be;
        wdata_q <= acc_wdata;
        idx_q   <= acc_idx;
        err_q   <= acc_err;
      end
      if (access) begin
        rsp_rdata_q <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
        rsp_err_q   <= acc_err;
      end
    end
  end

  // RAM has no reset; the write is suppressed on the reset edge.
  always_ff @(posedge clk_i) begin
    if (reset_ni && access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
